// File: rtl/y86_wb_regfile.sv
// Y86-64 write-back stage and register file: dst decode, two bypassed read ports,
// a debug read port, AOK/HLT/INS status tracking and a retired-instruction counter.

module y86_wb_reg_cell #(
  parameter int                DATA_W = 64,
  parameter logic [DATA_W-1:0] INIT   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)     q <= INIT;
    else if (we) q <= d;
  end
endmodule

module y86_wb_rdport #(
  parameter int DATA_W = 64,
  parameter int NREGS  = 15
) (
  input  logic [3:0]              addr,
  input  logic [15:0][DATA_W-1:0] rf,
  input  logic                    wen,
  input  logic [3:0]              dst_e,
  input  logic [3:0]              dst_m,
  input  logic [DATA_W-1:0]       val_e,
  input  logic [DATA_W-1:0]       val_m,
  output logic [DATA_W-1:0]       data
);
  localparam logic [4:0] NREGS_L = 5'(NREGS);

  logic addr_ok;
  assign addr_ok = {1'b0, addr} < NREGS_L;

  // Unimplemented entries of rf are tied to zero, so only the bypass needs the range guard.
  always_comb begin
    data = rf[addr];
    if (addr_ok && wen) begin
      if (addr == dst_m)      data = val_m;
      else if (addr == dst_e) data = val_e;
    end
  end
endmodule

module y86_wb_regfile #(
  parameter int                DATA_W   = 64,
  parameter int                NREGS    = 15,
  parameter logic [DATA_W-1:0] RSP_INIT = '0,
  parameter int                CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [3:0]        icode,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic              cnd,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  input  logic [3:0]        srcA,
  input  logic [3:0]        srcB,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  input  logic [3:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [1:0]        stat,
  output logic [CNT_W-1:0]  retired
);
  localparam int         NPORTS = 2;
  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_HLT  = 2'd1;
  localparam logic [1:0] S_INS  = 2'd2;

  logic [1:0]              state;
  logic                    run;
  logic                    wen;
  logic [3:0]              dst_e;
  logic [3:0]              dst_m;
  logic [15:0][DATA_W-1:0] rf;

  assign run = (state == S_RUN);
  // halt and invalid icodes never write, even though they count as retired
  assign wen = wb_valid && run && (icode != 4'h0) && (icode <= 4'hB);

  always_comb begin
    dst_e = 4'hF;
    dst_m = 4'hF;
    case (icode)
      4'h2:                   dst_e = cnd ? rB : 4'hF;
      4'h3, 4'h6:             dst_e = rB;
      4'h8, 4'h9, 4'hA, 4'hB: dst_e = 4'h4;
      default:                dst_e = 4'hF;
    endcase
    case (icode)
      4'h5, 4'hB: dst_m = rA;
      default:    dst_m = 4'hF;
    endcase
  end

  for (genvar i = 0; i < 16; i++) begin : g_reg
    if (i < NREGS) begin : g_cell
      logic hit_e, hit_m;
      assign hit_e = (dst_e == 4'(i));
      assign hit_m = (dst_m == 4'(i));
      // valM wins when both destinations name the same register (popq %rsp)
      y86_wb_reg_cell #(
        .DATA_W (DATA_W),
        .INIT   ((i == 4) ? RSP_INIT : {DATA_W{1'b0}})
      ) u_cell (
        .clk (clk),
        .rst (rst),
        .we  (wen && (hit_e || hit_m)),
        .d   (hit_m ? valM : valE),
        .q   (rf[i])
      );
    end else begin : g_none
      assign rf[i] = '0;
    end
  end

  logic [NPORTS-1:0][3:0]        rd_addr;
  logic [NPORTS-1:0][DATA_W-1:0] rd_data;

  assign rd_addr = {srcB, srcA};

  for (genvar p = 0; p < NPORTS; p++) begin : g_rd
    y86_wb_rdport #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS)
    ) u_rd (
      .addr  (rd_addr[p]),
      .rf    (rf),
      .wen   (wen),
      .dst_e (dst_e),
      .dst_m (dst_m),
      .val_e (valE),
      .val_m (valM),
      .data  (rd_data[p])
    );
  end

  assign valA     = rd_data[0];
  assign valB     = rd_data[1];
  assign dbg_data = rf[dbg_addr];
  assign stat     = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RUN;
    end else if (wb_valid && run) begin
      if (icode == 4'h0)      state <= S_HLT;
      else if (icode > 4'hB)  state <= S_INS;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                  retired <= '0;
    else if (wb_valid && run) retired <= retired + CNT_W'(1);
  end
endmodule

// File: tb/tb_y86_wb_regfile.sv
// Directed bench: a full-width core (RSP_INIT=256) and a narrow one (NREGS=8,
// DATA_W=32, CNT_W=4) driven step by step with hand-computed expectations.

module tb_y86_wb_regfile;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, wb_valid, cnd;
  logic [3:0]  icode, rA, rB, srcA, srcB, dbg_addr;
  logic [63:0] valE, valM, valA, valB, dbg_data;
  logic [1:0]  stat;
  logic [31:0] retired;

  logic        n_rst, n_wb_valid, n_cnd;
  logic [3:0]  n_icode, n_rA, n_rB, n_srcA, n_srcB, n_dbg_addr;
  logic [31:0] n_valE, n_valM, n_valA, n_valB, n_dbg_data;
  logic [1:0]  n_stat;
  logic [3:0]  n_retired;

  int checks = 0;
  int errors = 0;

  y86_wb_regfile #(.DATA_W(64), .NREGS(15), .RSP_INIT(64'd256), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .icode(icode), .rA(rA), .rB(rB),
    .cnd(cnd), .valE(valE), .valM(valM), .srcA(srcA), .srcB(srcB), .valA(valA),
    .valB(valB), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .stat(stat), .retired(retired)
  );

  y86_wb_regfile #(.DATA_W(32), .NREGS(8), .RSP_INIT(32'd0), .CNT_W(4)) dut_n (
    .clk(clk), .rst(n_rst), .wb_valid(n_wb_valid), .icode(n_icode), .rA(n_rA), .rB(n_rB),
    .cnd(n_cnd), .valE(n_valE), .valM(n_valM), .srcA(n_srcA), .srcB(n_srcB), .valA(n_valA),
    .valB(n_valB), .dbg_addr(n_dbg_addr), .dbg_data(n_dbg_data), .stat(n_stat),
    .retired(n_retired)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wb(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                    input logic c, input logic [63:0] e, input logic [63:0] m);
    wb_valid = 1'b1; icode = ic; rA = a; rB = b; cnd = c; valE = e; valM = m;
  endtask

  task automatic n_wb(input logic [3:0] ic, input logic [3:0] b, input logic [31:0] e);
    n_wb_valid = 1'b1; n_icode = ic; n_rA = 4'hF; n_rB = b; n_cnd = 1'b0;
    n_valE = e; n_valM = 32'h0;
  endtask

  task automatic clock();
    @(posedge clk); #1;
    wb_valid = 1'b0;
    n_wb_valid = 1'b0;
  endtask

  task automatic dbg(input string tag, input logic [3:0] a, input logic [63:0] exp);
    dbg_addr = a; #1;
    chk(tag, dbg_data, exp);
  endtask

  task automatic n_dbg(input string tag, input logic [3:0] a, input logic [31:0] exp);
    n_dbg_addr = a; #1;
    chk(tag, 64'(n_dbg_data), 64'(exp));
  endtask

  initial begin
    rst = 1'b1; wb_valid = 1'b0; icode = 4'h1; rA = 4'hF; rB = 4'hF; cnd = 1'b0;
    valE = '0; valM = '0; srcA = 4'hF; srcB = 4'hF; dbg_addr = 4'h0;
    n_rst = 1'b1; n_wb_valid = 1'b0; n_icode = 4'h1; n_rA = 4'hF; n_rB = 4'hF; n_cnd = 1'b0;
    n_valE = '0; n_valM = '0; n_srcA = 4'hF; n_srcB = 4'hF; n_dbg_addr = 4'h0;
    clock(); clock();
    rst = 1'b0; n_rst = 1'b0;

    for (int i = 0; i < 16; i++)
      dbg($sformatf("reset_reg%0d", i), 4'(i), (i == 4) ? 64'd256 : 64'd0);
    chk("reset_stat", 64'(stat), 64'd0);
    chk("reset_retired", 64'(retired), 64'd0);

    // irmovq $31, %rbx with same-cycle bypass
    wb(4'h3, 4'hF, 4'h3, 1'b0, 64'd31, 64'd0); srcA = 4'h3; #1;
    chk("irmovq_bypass_valA", valA, 64'd31);
    clock();
    dbg("irmovq_rbx", 4'h3, 64'd31);
    chk("irmovq_retired", 64'(retired), 64'd1);
    srcB = 4'h3; #1;
    chk("stored_valB_rbx", valB, 64'd31);

    wb(4'h2, 4'hF, 4'h2, 1'b0, 64'd7, 64'd0); clock();
    dbg("cmov_nc_rdx", 4'h2, 64'd0);
    wb(4'h2, 4'hF, 4'h2, 1'b1, 64'd7, 64'd0); clock();
    dbg("cmov_c_rdx", 4'h2, 64'd7);
    wb(4'h6, 4'hF, 4'h6, 1'b0, 64'h66, 64'd0); clock();
    dbg("opq_rsi", 4'h6, 64'h66);
    chk("retired_4", 64'(retired), 64'd4);

    // popq %rsp: valM wins over valE, also through the bypass
    wb(4'hB, 4'h4, 4'hF, 1'b0, 64'd264, 64'd99); srcA = 4'h4; #1;
    chk("popq_rsp_bypass", valA, 64'd99);
    clock();
    dbg("popq_rsp", 4'h4, 64'd99);
    wb(4'hB, 4'h3, 4'hF, 1'b0, 64'd264, 64'd99); clock();
    dbg("popq_rbx_rbx", 4'h3, 64'd99);
    dbg("popq_rbx_rsp", 4'h4, 64'd264);
    wb(4'h8, 4'hF, 4'hF, 1'b0, 64'd248, 64'd0); clock();
    dbg("call_rsp", 4'h4, 64'd248);

    wb(4'h5, 4'h2, 4'hF, 1'b0, 64'd0, 64'hDEAD); clock();
    dbg("mrmovq_rdx", 4'h2, 64'hDEAD);
    wb(4'h5, 4'hF, 4'hF, 1'b0, 64'h1111, 64'h2222); srcA = 4'hF; srcB = 4'h2; #1;
    chk("read_F_zero", valA, 64'd0);
    chk("valB_rdx_nobypass", valB, 64'hDEAD);
    clock();
    dbg("mrmovq_F_rdx", 4'h2, 64'hDEAD);
    dbg("mrmovq_F_rsp", 4'h4, 64'd248);
    chk("retired_9", 64'(retired), 64'd9);

    // wb_valid low: fields set but nothing happens
    icode = 4'h3; rB = 4'h1; valE = 64'd55; srcA = 4'h1; #1;
    chk("novalid_no_bypass", valA, 64'd0);
    clock();
    dbg("novalid_rcx", 4'h1, 64'd0);
    chk("novalid_retired", 64'(retired), 64'd9);

    wb(4'h0, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0); #1;
    chk("halt_stat_before", 64'(stat), 64'd0);
    clock();
    chk("halt_stat", 64'(stat), 64'd1);
    chk("halt_retired", 64'(retired), 64'd10);
    wb(4'h3, 4'hF, 4'h1, 1'b0, 64'd77, 64'd0); srcA = 4'h1; #1;
    chk("halted_no_bypass", valA, 64'd0);
    clock();
    dbg("halted_rcx", 4'h1, 64'd0);
    chk("halted_retired_frozen", 64'(retired), 64'd10);
    chk("halted_sticky", 64'(stat), 64'd1);

    // reset with a write in flight: the write is discarded
    rst = 1'b1; wb(4'h3, 4'hF, 4'h5, 1'b0, 64'd5, 64'd0); clock(); rst = 1'b0;
    chk("rst_stat", 64'(stat), 64'd0);
    chk("rst_retired", 64'(retired), 64'd0);
    dbg("rst_rsp", 4'h4, 64'd256);
    dbg("rst_rbx", 4'h3, 64'd0);
    dbg("rst_inflight_rbp", 4'h5, 64'd0);

    wb(4'hC, 4'hF, 4'h5, 1'b0, 64'd3, 64'd3); clock();
    chk("ins_stat", 64'(stat), 64'd2);
    chk("ins_retired", 64'(retired), 64'd1);
    dbg("ins_rbp", 4'h5, 64'd0);
    wb(4'h3, 4'hF, 4'h5, 1'b0, 64'd9, 64'd0); clock();
    dbg("ins_blocked_rbp", 4'h5, 64'd0);
    chk("ins_retired_frozen", 64'(retired), 64'd1);
    chk("ins_sticky", 64'(stat), 64'd2);

    // narrow instance: out-of-range index, last valid index, counter wrap
    n_wb(4'h3, 4'h9, 32'h99); n_srcA = 4'h9; #1;
    chk("n_r9_no_bypass", 64'(n_valA), 64'd0);
    clock();
    n_dbg("n_r9_read", 4'h9, 32'h0);
    n_wb(4'h3, 4'h7, 32'hABCD); n_srcB = 4'h7; #1;
    chk("n_r7_bypass", 64'(n_valB), 64'hABCD);
    clock();
    n_dbg("n_r7_read", 4'h7, 32'hABCD);
    chk("n_retired_2", 64'(n_retired), 64'd2);
    for (int k = 0; k < 13; k++) begin
      n_wb(4'h1, 4'hF, 32'h0); clock();
    end
    chk("n_retired_15", 64'(n_retired), 64'd15);
    n_wb(4'h1, 4'hF, 32'h0); clock();
    chk("n_retired_wrap", 64'(n_retired), 64'd0);
    chk("n_stat_run", 64'(n_stat), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/y86_wb_regfile.md
# y86_wb_regfile

Parametrised write-back stage and register file for the Y86-64 sequential and pipelined cores. It replaces the fixed 64-bit, 15-register write-back with a configurable one, and decodes the destination registers from icode, rA, rB and cnd. It provides two bypassed read ports for decode and tracks processor status (AOK/HLT/INS) with a small state machine. It also counts retired instructions. It sits between memory (valE, valM) and decode (valA, valB).

## Interface
Parameters:
- DATA_W, 64, register and data width
- NREGS, 15, number of architectural registers (1..15); encoding 4'hF is always "no register"
- RSP_INIT, 0, reset value of register 4 (%rsp); all others reset to 0
- CNT_W, 32, retired-instruction counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- wb_valid  in  1  instruction in write-back is valid this cycle
- icode  in  4  instruction code
- rA, rB  in  4  register specifiers
- cnd  in  1  condition result from execute
- valE, valM  in  DATA_W  execute result and memory read data
- srcA, srcB  in  4  decode read addresses
- valA, valB  out  DATA_W  read data (combinational, bypassed)
- dbg_addr  in  4  debug read address
- dbg_data  out  DATA_W  debug read data, not bypassed
- stat  out  2  0=AOK, 1=HLT, 2=INS
- retired  out  CNT_W  count of retired instructions

## Operation
- Register encoding: 0 rax, 1 rcx, 2 rdx, 3 rbx, 4 rsp, 5 rbp, 6 rsi, 7 rdi, 8–14 r8–r14.
- dstE decode:
  - cmovxx (2): rB if cnd, else F
  - irmovq (3) and OPq (6): rB
  - call (8), ret (9), pushq (A), popq (B): 4
  - all others: F
- dstM decode:
  - mrmovq (5) and popq (B): rA
  - all others: F
- Write: when wb_valid and state RUN, write valE to dstE and valM to dstM.
  - F or an index ≥ NREGS is not written.
  - If dstE == dstM, valM wins. This covers popq %rsp.
- Read of address F or an index ≥ NREGS returns 0. The same applies to dbg_data.
- Bypass: valA/valB return the value being written this cycle when wb_valid, state RUN, and the address matches dstM or dstE (dstM has priority). Otherwise they return the stored value.
- State machine:
  - States are RUN, HALTED and INVALID. Reset enters RUN.
  - RUN → HALTED on wb_valid with icode 0.
  - RUN → INVALID on wb_valid with icode > 4'hB.
  - HALTED and INVALID are sticky until rst.
  - stat is 0 in RUN, 1 in HALTED, 2 in INVALID.
- No register writes happen in HALTED or INVALID, or on the halt or invalid instruction itself.
- retired increments on every wb_valid cycle in RUN, including halt and invalid instructions. It wraps modulo 2^CNT_W and is frozen outside RUN.
- wb_valid = 0: no writes, no counting, no state change. Bypass is disabled.

## Timing
- All writes, state transitions and counter updates happen on the rising clk edge. Stored values are visible one cycle after the write edge; bypassed values are visible in the same cycle.
- Read paths are purely combinational; there is no read latency.
- Reset behaviour:
  - rst high at an edge: all registers 0 except reg 4 = RSP_INIT; stat = 0; retired = 0.
  - rst has priority over any simultaneous write.
  - Reset mid-program discards the in-flight write.
- The HALT/INS transition takes effect at the same edge as the offending instruction. stat reads 1 or 2 from the next cycle on.

## Test plan
- Reset with RSP_INIT=256: after rst, dbg_addr=4 → 256; dbg_addr=0..14 (except 4) → 0; stat=0; retired=0.
- irmovq sequence:
  - icode=3, rB=3, valE=31, wb_valid=1: in the same cycle srcA=3 → valA=31 via bypass; after the edge dbg_addr=3 → 31; retired=1.
  - cmovxx icode=2, rB=2, valE=7 with cnd=0: reg 2 unchanged.
  - Same with cnd=1: reg 2 = 7.
- popq %rsp: icode=B, rA=4, valE=264, valM=99 → reg 4 = 99. popq %rbx with the same values → rbx=99, rsp=264.
- mrmovq icode=5, rA=2, valM=0xDEAD → rdx=0xDEAD. With rA=F, no register changes.
- Halt:
  - icode=0 with wb_valid → stat=1 next cycle; retired increments once.
  - A following irmovq to rB=1 does not write rcx, and retired is frozen.
  - rst → stat=0.
- Invalid and width cases:
  - icode=C → stat=2; later writes are blocked.
  - NREGS=8, DATA_W=32: a write to r9 is ignored and a read of r9 returns 0.
  - CNT_W=4: 16 retired instructions wrap retired to 0.
